// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types and helpers for the ID-stage hazard controller: forwarding-select
// encoding, the shadow pipeline entry and the register-match function.
package hazard_pkg;

    typedef enum logic [1:0] {
        FWD_REG = 2'd0,
        FWD_EX  = 2'd1,
        FWD_MEM = 2'd2
    } fwd_sel_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       reg_write;
        logic       mem_read;
        logic       set_flags;
    } stage_ent_t;

    localparam logic [4:0] ZERO_REG = 5'd31;

    localparam stage_ent_t EMPTY_ENT = '{
        valid:     1'b0,
        rd:        5'd0,
        reg_write: 1'b0,
        mem_read:  1'b0,
        set_flags: 1'b0
    };

    // XZR is hard-wired zero, so it can never be a producer worth forwarding from
    function automatic logic src_match(stage_ent_t ent, logic [4:0] src, logic used);
        return used & ent.valid & ent.reg_write & (ent.rd == src) & (src != ZERO_REG);
    endfunction

    function automatic fwd_sel_t fwd_pick(logic ex_hit, logic mem_hit);
        fwd_sel_t sel;
        if (ex_hit) begin
            sel = FWD_EX;
        end else if (mem_hit) begin
            sel = FWD_MEM;
        end else begin
            sel = FWD_REG;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Decode-stage hazard bundle: decoded ID fields in, pipeline gating and forwarding selects out.
interface pipeline_hazard_ctrl_if;

    logic       id_valid;
    logic [4:0] id_rn;
    logic [4:0] id_rm;
    logic [4:0] id_rd;
    logic       id_use_rn;
    logic       id_use_rm;
    logic       id_rd_src;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       id_is_mul;
    logic       id_set_flags;
    logic       id_use_flags;
    logic       id_br_taken;

    logic       pc_stall;
    logic       ifid_stall;
    logic       ifid_flush;
    logic       idex_bubble;
    logic [1:0] fwd_a_sel;
    logic [1:0] fwd_b_sel;
    logic       flag_fwd;
    logic       mul_busy;

    modport master (
        output id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_rd_src,
               id_reg_write, id_mem_read, id_is_mul, id_set_flags, id_use_flags,
               id_br_taken,
        input  pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel,
               flag_fwd, mul_busy
    );

    modport slave (
        input  id_valid, id_rn, id_rm, id_rd, id_use_rn, id_use_rm, id_rd_src,
               id_reg_write, id_mem_read, id_is_mul, id_set_flags, id_use_flags,
               id_br_taken,
        output pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a_sel, fwd_b_sel,
               flag_fwd, mul_busy
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_chk.sv
// Structural invariants of the hazard controller outputs, observed on every clock.
module pipeline_hazard_ctrl_chk (
    input logic       clk,
    input logic       reset,
    input logic       pc_stall,
    input logic       ifid_stall,
    input logic       ifid_flush,
    input logic       idex_bubble,
    input logic [1:0] fwd_a_sel,
    input logic [1:0] fwd_b_sel,
    input logic       mul_busy
);

    a_stall_pair: assert property (@(posedge clk) disable iff (reset)
        pc_stall == ifid_stall);

    a_flush_excl: assert property (@(posedge clk) disable iff (reset)
        !(ifid_flush && pc_stall));

    a_bubble_stalls: assert property (@(posedge clk) disable iff (reset)
        idex_bubble |-> pc_stall);

    a_busy_holds: assert property (@(posedge clk) disable iff (reset)
        mul_busy |-> (pc_stall && !idex_bubble));

    a_fwd_enc: assert property (@(posedge clk) disable iff (reset)
        (fwd_a_sel != 2'd3) && (fwd_b_sel != 2'd3));

endmodule

// File: rtl/pipeline_hazard_ctrl_mul_busy_counter.sv
// Counts the extra EX cycles a multiply occupies; busy while the count is non-zero.
module mul_busy_counter #(
    parameter int MUL_LAT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic busy
);

    localparam int            CW       = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] LOAD_VAL = CW'(MUL_LAT - 1);
    localparam logic [CW-1:0] CNT_ZERO = CW'(0);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    logic [CW-1:0] cnt_r;

    // remaining-cycle counter: load on MUL entry, count down to zero
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_r <= CNT_ZERO;
        end else if (load) begin
            cnt_r <= LOAD_VAL;
        end else if (cnt_r != CNT_ZERO) begin
            cnt_r <= cnt_r - CNT_ONE;
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign busy = (cnt_r != CNT_ZERO);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// ID-stage hazard controller: shadows EX/MEM destination info, raises load-use, flag and
// MUL stalls, squashes the fetch slot on taken branches and drives the ID forwarding selects.
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MUL_LAT    = 3,
    parameter int DELAY_SLOT = 1
) (
    input  logic                  clk,
    input  logic                  reset,
    pipeline_hazard_ctrl_if.slave hif
);

    stage_ent_t ex_r;
    stage_ent_t mem_r;
    stage_ent_t ex_next_s;

    logic       use_a_s;
    logic       use_b_s;
    logic       use_rm_side_s;
    logic [4:0] src_b_s;
    logic       ex_a_s;
    logic       ex_b_s;
    logic       ex_rm_s;
    logic       mem_a_s;
    logic       mem_b_s;
    logic       load_use_s;
    logic       flag_ex_s;
    logic       flag_mem_s;
    logic       hazard_s;
    logic       mul_busy_s;
    logic       mul_load_s;
    logic       br_squash_s;

    assign use_a_s = hif.id_valid & hif.id_use_rn;
    assign use_b_s = hif.id_valid & (hif.id_rd_src | hif.id_use_rm);
    assign src_b_s = hif.id_rd_src ? hif.id_rd : hif.id_rm;
    // when port B carries rd, a used rm still has to be checked for load-use
    assign use_rm_side_s = hif.id_valid & hif.id_rd_src & hif.id_use_rm;

    assign ex_a_s  = src_match(ex_r,  hif.id_rn, use_a_s);
    assign ex_b_s  = src_match(ex_r,  src_b_s,   use_b_s);
    assign ex_rm_s = src_match(ex_r,  hif.id_rm, use_rm_side_s);
    assign mem_a_s = src_match(mem_r, hif.id_rn, use_a_s);
    assign mem_b_s = src_match(mem_r, src_b_s,   use_b_s);

    assign load_use_s = ex_r.mem_read & (ex_a_s | ex_b_s | ex_rm_s);
    assign flag_ex_s  = hif.id_valid & hif.id_use_flags & ex_r.valid & ex_r.set_flags;
    // a younger flag setter in EX supersedes the MEM one, so no stall is needed then
    assign flag_mem_s = hif.id_valid & hif.id_use_flags & mem_r.valid & mem_r.set_flags
                        & ~flag_ex_s;
    assign hazard_s   = load_use_s | flag_mem_s;

    assign br_squash_s = hif.id_valid & hif.id_br_taken & (DELAY_SLOT == 0);
    assign mul_load_s  = hif.id_valid & hif.id_is_mul & ~mul_busy_s & ~hazard_s;

    mul_busy_counter #(
        .MUL_LAT (MUL_LAT)
    ) u_mul_cnt (
        .clk   (clk),
        .reset (reset),
        .load  (mul_load_s),
        .busy  (mul_busy_s)
    );

    // pipeline gating, highest priority first: MUL hold, then bubble stall, then squash
    always_comb begin
        hif.pc_stall    = 1'b0;
        hif.ifid_stall  = 1'b0;
        hif.ifid_flush  = 1'b0;
        hif.idex_bubble = 1'b0;
        if (mul_busy_s) begin
            hif.pc_stall   = 1'b1;
            hif.ifid_stall = 1'b1;
        end else if (hazard_s) begin
            hif.pc_stall    = 1'b1;
            hif.ifid_stall  = 1'b1;
            hif.idex_bubble = 1'b1;
        end else if (br_squash_s) begin
            hif.ifid_flush = 1'b1;
        end else begin
            hif.ifid_flush = 1'b0;
        end
    end

    assign hif.fwd_a_sel = fwd_pick(ex_a_s, mem_a_s);
    assign hif.fwd_b_sel = fwd_pick(ex_b_s, mem_b_s);
    assign hif.flag_fwd  = flag_ex_s;
    assign hif.mul_busy  = mul_busy_s;

    // entry presented to the EX shadow stage on the next edge
    always_comb begin
        ex_next_s = EMPTY_ENT;
        if (hif.id_valid & ~hazard_s) begin
            ex_next_s.valid     = 1'b1;
            ex_next_s.rd        = hif.id_rd;
            ex_next_s.reg_write = hif.id_reg_write;
            ex_next_s.mem_read  = hif.id_mem_read;
            ex_next_s.set_flags = hif.id_set_flags;
        end else begin
            ex_next_s = EMPTY_ENT;
        end
    end

    // shadow EX/MEM advance; a busy MUL holds EX and sends a bubble down to MEM
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ex_r  <= EMPTY_ENT;
            mem_r <= EMPTY_ENT;
        end else if (mul_busy_s) begin
            ex_r  <= ex_r;
            mem_r <= EMPTY_ENT;
        end else begin
            ex_r  <= ex_next_s;
            mem_r <= ex_r;
        end
    end

    pipeline_hazard_ctrl_chk u_chk (
        .clk         (clk),
        .reset       (reset),
        .pc_stall    (hif.pc_stall),
        .ifid_stall  (hif.ifid_stall),
        .ifid_flush  (hif.ifid_flush),
        .idex_bubble (hif.idex_bubble),
        .fwd_a_sel   (hif.fwd_a_sel),
        .fwd_b_sel   (hif.fwd_b_sel),
        .mul_busy    (hif.mul_busy)
    );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: instruction sequences are issued into ID and the
// expected gating/forwarding vector for each ID cycle is queued and compared mid-cycle.
module tb_pipeline_hazard_ctrl;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic [4:0] rn;
        logic [4:0] rm;
        logic       use_rn;
        logic       use_rm;
        logic       rd_src;
        logic       reg_write;
        logic       mem_read;
        logic       is_mul;
        logic       set_flags;
        logic       use_flags;
        logic       br_taken;
    } instr_t;

    typedef struct {
        string      name;
        logic [9:0] exp;
    } sb_ent_t;

    localparam logic       L  = 1'b0;
    localparam logic       H  = 1'b1;
    localparam logic [1:0] F0 = 2'd0;
    localparam logic [1:0] F1 = 2'd1;
    localparam logic [1:0] F2 = 2'd2;
    localparam logic [9:0] ZV = 10'd0;

    logic    clk;
    logic    reset;
    instr_t  cur;
    int      checks   = 0;
    int      failures = 0;
    sb_ent_t sb[$];

    pipeline_hazard_ctrl_if hif0();
    pipeline_hazard_ctrl_if hif1();

    assign hif0.id_valid = cur.valid;     assign hif1.id_valid = cur.valid;
    assign hif0.id_rn = cur.rn;           assign hif1.id_rn = cur.rn;
    assign hif0.id_rm = cur.rm;           assign hif1.id_rm = cur.rm;
    assign hif0.id_rd = cur.rd;           assign hif1.id_rd = cur.rd;
    assign hif0.id_use_rn = cur.use_rn;   assign hif1.id_use_rn = cur.use_rn;
    assign hif0.id_use_rm = cur.use_rm;   assign hif1.id_use_rm = cur.use_rm;
    assign hif0.id_rd_src = cur.rd_src;   assign hif1.id_rd_src = cur.rd_src;
    assign hif0.id_reg_write = cur.reg_write; assign hif1.id_reg_write = cur.reg_write;
    assign hif0.id_mem_read = cur.mem_read;   assign hif1.id_mem_read = cur.mem_read;
    assign hif0.id_is_mul = cur.is_mul;       assign hif1.id_is_mul = cur.is_mul;
    assign hif0.id_set_flags = cur.set_flags; assign hif1.id_set_flags = cur.set_flags;
    assign hif0.id_use_flags = cur.use_flags; assign hif1.id_use_flags = cur.use_flags;
    assign hif0.id_br_taken = cur.br_taken;   assign hif1.id_br_taken = cur.br_taken;

    pipeline_hazard_ctrl #(.MUL_LAT(3), .DELAY_SLOT(0)) u_dut0 (
        .clk (clk), .reset (reset), .hif (hif0)
    );

    pipeline_hazard_ctrl #(.MUL_LAT(3), .DELAY_SLOT(1)) u_dut1 (
        .clk (clk), .reset (reset), .hif (hif1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic instr_t i_nop();
        instr_t t = '0;
        return t;
    endfunction

    function automatic instr_t i_alu(input logic [4:0] rd, input logic [4:0] rn,
                                     input logic [4:0] rm, input logic sf);
        instr_t t = '0;
        t.valid = H; t.rd = rd; t.rn = rn; t.rm = rm;
        t.use_rn = H; t.use_rm = H; t.reg_write = H; t.set_flags = sf;
        return t;
    endfunction

    function automatic instr_t i_ldr(input logic [4:0] rd, input logic [4:0] rn);
        instr_t t = '0;
        t.valid = H; t.rd = rd; t.rn = rn; t.use_rn = H; t.reg_write = H; t.mem_read = H;
        return t;
    endfunction

    function automatic instr_t i_str(input logic [4:0] rd, input logic [4:0] rn);
        instr_t t = '0;
        t.valid = H; t.rd = rd; t.rn = rn; t.use_rn = H; t.rd_src = H;
        return t;
    endfunction

    function automatic instr_t i_mul(input logic [4:0] rd, input logic [4:0] rn,
                                     input logic [4:0] rm);
        instr_t t = i_alu(rd, rn, rm, L);
        t.is_mul = H;
        return t;
    endfunction

    function automatic instr_t i_blt(input logic taken);
        instr_t t = '0;
        t.valid = H; t.use_flags = H; t.br_taken = taken;
        return t;
    endfunction

    // {pc_stall, ifid_stall, ifid_flush, idex_bubble, fwd_a, fwd_b, flag_fwd, mul_busy}
    function automatic logic [9:0] ev(input logic st, input logic fl, input logic bub,
                                      input logic [1:0] fa, input logic [1:0] fb,
                                      input logic ff, input logic mb);
        return {st, st, fl, bub, fa, fb, ff, mb};
    endfunction

    function automatic logic [9:0] obs0();
        return {hif0.pc_stall, hif0.ifid_stall, hif0.ifid_flush, hif0.idex_bubble,
                hif0.fwd_a_sel, hif0.fwd_b_sel, hif0.flag_fwd, hif0.mul_busy};
    endfunction

    task automatic issue(input instr_t t, input string name, input logic [9:0] exp);
        sb_ent_t e;
        cur    = t;
        e.name = name;
        e.exp  = exp;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        instr_t     ins[2];
        logic [9:0] exv[2];
        sb_ent_t    e;
        ins[0] = i_mul(5'd6, 5'd1, 5'd2);  exv[0] = ZV;
        ins[1] = i_alu(5'd8, 5'd6, 5'd3, L); exv[1] = ZV;
        for (int i = 0; i < 2; i++) begin
            issue(ins[i], "reset", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
        reset = 1'b0;
    endtask

    task automatic test_fwd_ex();
        instr_t     ins[5];
        logic [9:0] exv[5];
        sb_ent_t    e;
        ins[0] = i_alu(5'd1, 5'd2, 5'd3, H); exv[0] = ZV;
        ins[1] = i_alu(5'd2, 5'd1, 5'd3, L); exv[1] = ev(L, L, L, F1, F0, L, L);
        ins[2] = i_alu(5'd7, 5'd2, 5'd1, L); exv[2] = ev(L, L, L, F1, F2, L, L);
        ins[3] = i_nop();                    exv[3] = ZV;
        ins[4] = i_nop();                    exv[4] = ZV;
        for (int i = 0; i < 5; i++) begin
            issue(ins[i], "fwd_ex", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load_use();
        instr_t     ins[10];
        logic [9:0] exv[10];
        sb_ent_t    e;
        ins[0] = i_ldr(5'd4, 5'd9);          exv[0] = ZV;
        ins[1] = i_alu(5'd5, 5'd4, 5'd4, L); exv[1] = ev(H, L, H, F1, F1, L, L);
        ins[2] = ins[1];                     exv[2] = ev(L, L, L, F2, F2, L, L);
        ins[3] = i_nop();                    exv[3] = ZV;
        ins[4] = i_nop();                    exv[4] = ZV;
        ins[5] = i_ldr(5'd4, 5'd9);          exv[5] = ZV;
        ins[6] = i_str(5'd4, 5'd8);          exv[6] = ev(H, L, H, F0, F1, L, L);
        ins[7] = ins[6];                     exv[7] = ev(L, L, L, F0, F2, L, L);
        ins[8] = i_nop();                    exv[8] = ZV;
        ins[9] = i_nop();                    exv[9] = ZV;
        for (int i = 0; i < 10; i++) begin
            issue(ins[i], "load_use", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_mul();
        instr_t     ins[6];
        logic [9:0] exv[6];
        sb_ent_t    e;
        ins[0] = i_mul(5'd6, 5'd1, 5'd2);    exv[0] = ZV;
        ins[1] = i_alu(5'd8, 5'd6, 5'd3, L); exv[1] = ev(H, L, L, F1, F0, L, H);
        ins[2] = ins[1];                     exv[2] = ev(H, L, L, F1, F0, L, H);
        ins[3] = ins[1];                     exv[3] = ev(L, L, L, F1, F0, L, L);
        ins[4] = i_nop();                    exv[4] = ZV;
        ins[5] = i_nop();                    exv[5] = ZV;
        for (int i = 0; i < 6; i++) begin
            issue(ins[i], "mul", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_flags();
        instr_t     ins[10];
        logic [9:0] exv[10];
        sb_ent_t    e;
        ins[0] = i_alu(5'd1, 5'd2, 5'd3, H); exv[0] = ZV;
        ins[1] = i_blt(L);                   exv[1] = ev(L, L, L, F0, F0, H, L);
        ins[2] = i_nop();                    exv[2] = ZV;
        ins[3] = i_nop();                    exv[3] = ZV;
        ins[4] = i_alu(5'd1, 5'd2, 5'd3, H); exv[4] = ZV;
        ins[5] = i_nop();                    exv[5] = ZV;
        ins[6] = i_blt(H);                   exv[6] = ev(H, L, H, F0, F0, L, L);
        ins[7] = i_blt(H);                   exv[7] = ev(L, H, L, F0, F0, L, L);
        ins[8] = i_nop();                    exv[8] = ZV;
        ins[9] = i_nop();                    exv[9] = ZV;
        for (int i = 0; i < 10; i++) begin
            issue(ins[i], "flags", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            checks++;
            if (hif1.ifid_flush !== 1'b0) begin
                failures++;
                $display("FAIL delay_slot_flush[%0d]: got %b expected 0", i, hif1.ifid_flush);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_xzr();
        instr_t     ins[5];
        logic [9:0] exv[5];
        sb_ent_t    e;
        ins[0] = i_ldr(5'd31, 5'd2);            exv[0] = ZV;
        ins[1] = i_alu(5'd9, 5'd31, 5'd31, L);  exv[1] = ZV;
        ins[2] = i_alu(5'd10, 5'd31, 5'd9, L);  exv[2] = ev(L, L, L, F0, F1, L, L);
        ins[3] = i_nop();                       exv[3] = ZV;
        ins[4] = i_nop();                       exv[4] = ZV;
        for (int i = 0; i < 5; i++) begin
            issue(ins[i], "xzr", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_unused_invalid();
        instr_t     ins[6];
        logic [9:0] exv[6];
        sb_ent_t    e;
        ins[0] = i_ldr(5'd4, 5'd9);          exv[0] = ZV;
        ins[1] = i_alu(5'd7, 5'd4, 5'd4, L);
        ins[1].use_rn = L; ins[1].use_rm = L; exv[1] = ZV;
        ins[2] = i_ldr(5'd4, 5'd9);          exv[2] = ZV;
        ins[3] = i_alu(5'd5, 5'd4, 5'd4, L);
        ins[3].valid = L;                    exv[3] = ZV;
        ins[4] = i_nop();                    exv[4] = ZV;
        ins[5] = i_nop();                    exv[5] = ZV;
        for (int i = 0; i < 6; i++) begin
            issue(ins[i], "unused_invalid", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_back_to_back();
        instr_t     ins[5];
        logic [9:0] exv[5];
        sb_ent_t    e;
        ins[0] = i_alu(5'd1, 5'd2, 5'd3, L); exv[0] = ZV;
        ins[1] = i_alu(5'd1, 5'd1, 5'd3, L); exv[1] = ev(L, L, L, F1, F0, L, L);
        ins[2] = i_alu(5'd2, 5'd1, 5'd1, L); exv[2] = ev(L, L, L, F1, F1, L, L);
        ins[3] = i_nop();                    exv[3] = ZV;
        ins[4] = i_nop();                    exv[4] = ZV;
        for (int i = 0; i < 5; i++) begin
            issue(ins[i], "back_to_back", exv[i]);
            @(negedge clk);
            e = sb.pop_front();
            checks++;
            if (obs0() !== e.exp) begin
                failures++;
                $display("FAIL %s[%0d]: got %b expected %b", e.name, i, obs0(), e.exp);
            end
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_mul();
        sb_ent_t e;
        issue(i_mul(5'd6, 5'd1, 5'd2), "rst_mul_issue", ZV);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        @(posedge clk); #1;
        issue(i_alu(5'd8, 5'd6, 5'd3, L), "rst_mul_busy", ev(H, L, L, F1, F0, L, H));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        #2;
        reset = 1'b1;
        sb.push_back('{name: "rst_mul_async", exp: ZV});
        #1;
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        #1;
        reset = 1'b0;
        @(posedge clk); #1;
        issue(i_alu(5'd8, 5'd6, 5'd3, L), "rst_mul_after", ZV);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        @(posedge clk); #1;
        issue(i_alu(5'd9, 5'd8, 5'd1, L), "rst_mul_flow", ev(L, L, L, F1, F0, L, L));
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        @(posedge clk); #1;
        issue(i_nop(), "rst_mul_drain", ZV);
        @(negedge clk);
        e = sb.pop_front();
        checks++;
        if (obs0() !== e.exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b", e.name, obs0(), e.exp);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        cur   = i_nop();
        @(posedge clk); #1;
        test_reset();
        test_fwd_ex();
        test_load_use();
        test_mul();
        test_flags();
        test_xzr();
        test_unused_invalid();
        test_back_to_back();
        test_reset_mid_mul();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
